// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control sequencer.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR,
    MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUSRCA_PC    = 2'b00;
  localparam logic [1:0] ALUSRCA_RS1   = 2'b01;
  localparam logic [1:0] ALUSRCA_OLDPC = 2'b10;

  localparam logic [1:0] ALUSRCB_RS2     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH1 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_mem_wait(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive unanswered memory-request cycles and flags expiry on the TIMEOUT-th one.
module mem_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wait_i,
  input  logic ready_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;

  // A ready in the same cycle as the final wait suppresses expiry.
  assign stall    = wait_i && !ready_i;
  assign expire_o = stall && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (stall && !expire_o) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control sequencer for the multicycle RV32I datapath with retire counter and memory watchdog.
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_rw,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       dbg_state,
  output logic             dbg_taken
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, bus_error_q;
  logic             retire, set_illegal, set_bus_error;
  logic             wd_expire;

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i    (CLK),
    .rst_i    (RST),
    .wait_i   (is_mem_wait(state_q)),
    .ready_i  (mem_ready),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    set_illegal   = 1'b0;
    set_bus_error = 1'b0;
    mem_req       = 1'b0;
    mem_rw        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PCSRC_ALU;
    alu_src_a     = ALUSRCA_PC;
    alu_src_b     = ALUSRCB_RS2;
    alu_op        = ALUOP_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = ALUSRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        alu_src_a = ALUSRCA_OLDPC;
        alu_src_b = ALUSRCB_IMM_SH1;
        case (opcode)
          OP_R:               state_d = EXEC_R;
          OP_I:               state_d = EXEC_I;
          OP_LOAD, OP_STORE:  state_d = ADDR;
          OP_BRANCH:          state_d = BRANCH;
          default: begin
            state_d     = TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a = ALUSRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        state_d   = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a = ALUSRCA_RS1;
        alu_src_b = ALUSRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = WB_ALU;
      end
      ADDR: begin
        alu_src_a = ALUSRCA_RS1;
        alu_src_b = ALUSRCB_IMM;
        state_d   = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = WB_MEM;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_rw  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      WB_ALU: begin
        reg_write = 1'b1;
        state_d   = FETCH;
        retire    = 1'b1;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
        retire     = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = ALUSRCA_RS1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        state_d       = FETCH;
        retire        = 1'b1;
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
    // Expiry only fires while stalled, so it never collides with a retire.
    if (wd_expire) begin
      state_d       = TRAP;
      set_bus_error = 1'b1;
    end
  end

  assign retired_d = retired_q + CNT_W'(retire);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      retired_q   <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      retired_q   <= retired_d;
      illegal_q   <= illegal_q | set_illegal;
      bus_error_q <= bus_error_q | set_bus_error;
    end
  end

  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;
  assign retired   = retired_q;
  assign dbg_state = state_q;
  assign dbg_taken = (state_q == BRANCH) && zero;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Cycle-accurate bench for multicycle_ctrl_fsm: per-cycle control snapshots checked via an expected queue.
module tb_multicycle_ctrl_fsm;
  import rv_ctrl_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [6:0]       opcode = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_rw, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0]       pc_src, alu_src_a, alu_src_b, alu_op;
  logic             reg_write, mem_to_reg, illegal, bus_error;
  logic [CNT_W-1:0] retired;
  logic [3:0]       dbg_state;
  logic             dbg_taken;

  multicycle_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_rw(mem_rw), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .bus_error(bus_error), .retired(retired), .dbg_state(dbg_state),
    .dbg_taken(dbg_taken)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  int          exp_ret = 0;
  logic [20:0] exp_q[$];
  logic [20:0] obs_snap;

  assign obs_snap = {dbg_taken, dbg_state, mem_req, mem_rw, iord, ir_write, pc_write,
                     pc_write_cond, pc_src, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected control word for a given state, mem_ready and zero, straight from the control table.
  function automatic logic [20:0] snap_model(input state_t s, input logic rdy, input logic z);
    logic       req, rw, io, irw, pcw, pcwc, regw, m2r, tk;
    logic [1:0] psrc, sa, sb, op;
    {req, rw, io, irw, pcw, pcwc, regw, m2r, tk} = '0;
    {psrc, sa, sb, op} = '0;
    case (s)
      FETCH:  begin req = 1; irw = rdy; pcw = rdy; sb = 2'b01; end
      DECODE: begin sa = 2'b10; sb = 2'b11; end
      EXEC_R: begin sa = 2'b01; op = 2'b10; end
      EXEC_I: begin sa = 2'b01; sb = 2'b10; op = 2'b10; end
      ADDR:   begin sa = 2'b01; sb = 2'b10; end
      MEM_RD: begin req = 1; io = 1; end
      MEM_WR: begin req = 1; rw = 1; io = 1; end
      WB_ALU: begin regw = 1; end
      WB_MEM: begin regw = 1; m2r = 1; end
      BRANCH: begin sa = 2'b01; op = 2'b01; pcwc = 1; psrc = 2'b01; tk = z; end
      default: ;
    endcase
    return {tk, 4'(s), req, rw, io, irw, pcw, pcwc, psrc, sa, sb, op, regw, m2r};
  endfunction

  // Drive one cycle: inputs at the falling edge, expected word queued, outputs compared 1 ns later.
  task automatic step(input state_t s, input logic rdy, input string tag);
    logic [20:0] e;
    mem_ready = rdy;
    exp_q.push_back(snap_model(s, rdy, zero));
    #1;
    e = exp_q.pop_front();
    check(tag, 32'(obs_snap), 32'(e));
    @(negedge CLK);
  endtask

  task automatic do_reset();
    logic [20:0] e;
    RST = 1'b1;
    mem_ready = rnd();
    exp_q.push_back(snap_model(IDLE, mem_ready, zero));
    #1;
    e = exp_q.pop_front();
    check("rst_snap", 32'(obs_snap), 32'(e));
    check("rst_retired", retired, 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_bus_error", 32'(bus_error), 0);
    @(negedge CLK);
    RST = 1'b0;
    exp_ret = 0;
    step(IDLE, rnd(), "idle");
  endtask

  task automatic fetch(input int fw);
    for (int i = 0; i < fw; i++) step(FETCH, 1'b0, "fetch_wait");
    step(FETCH, 1'b1, "fetch_done");
  endtask

  task automatic run_alu(input logic [6:0] op, input int fw);
    opcode = op;
    fetch(fw);
    step(DECODE, rnd(), "decode");
    step((op == 7'b0110011) ? EXEC_R : EXEC_I, rnd(), "exec");
    step(WB_ALU, rnd(), "wb_alu");
    exp_ret++;
    check("retired_alu", retired, exp_ret);
  endtask

  task automatic run_load(input int fw, input int mw);
    opcode = 7'b0000011;
    fetch(fw);
    step(DECODE, rnd(), "decode");
    step(ADDR, rnd(), "addr");
    for (int i = 0; i < mw; i++) step(MEM_RD, 1'b0, "mem_rd_wait");
    step(MEM_RD, 1'b1, "mem_rd_done");
    step(WB_MEM, rnd(), "wb_mem");
    exp_ret++;
    check("retired_load", retired, exp_ret);
  endtask

  task automatic run_store(input int fw, input int mw);
    opcode = 7'b0100011;
    fetch(fw);
    step(DECODE, rnd(), "decode");
    step(ADDR, rnd(), "addr");
    for (int i = 0; i < mw; i++) step(MEM_WR, 1'b0, "mem_wr_wait");
    step(MEM_WR, 1'b1, "mem_wr_done");
    exp_ret++;
    check("retired_store", retired, exp_ret);
  endtask

  task automatic run_branch(input int fw, input logic z);
    opcode = 7'b1100011;
    zero = z;
    fetch(fw);
    step(DECODE, rnd(), "decode");
    step(BRANCH, rnd(), "branch");
    exp_ret++;
    check("retired_branch", retired, exp_ret);
  endtask

  initial begin
    @(negedge CLK);
    do_reset();

    run_alu(7'b0110011, 0);
    run_load(0, 2);
    run_store(0, 0);
    run_branch(0, 1'b1);
    run_branch(0, 1'b0);
    run_alu(7'b0010011, 1);

    // Undecodable opcode: trap is absorbing and freezes the counter.
    opcode = 7'b1111111;
    fetch(0);
    step(DECODE, rnd(), "decode_bad");
    for (int i = 0; i < 20; i++) step(TRAP, rnd(), "trap_illegal");
    check("illegal_set", 32'(illegal), 1);
    check("retired_frozen", retired, exp_ret);
    do_reset();

    // Unanswered fetch for TIMEOUT cycles traps with bus_error.
    opcode = 7'b0110011;
    for (int i = 0; i < TIMEOUT; i++) step(FETCH, 1'b0, "fetch_stall");
    step(TRAP, rnd(), "trap_bus");
    check("bus_error_set", 32'(bus_error), 1);
    check("illegal_clear", 32'(illegal), 0);
    do_reset();

    // Ready on the TIMEOUT-th cycle wins over the watchdog.
    run_alu(7'b0110011, TIMEOUT - 1);
    check("bus_error_clear", 32'(bus_error), 0);

    // Reset while a store is pending drops the request immediately.
    opcode = 7'b0100011;
    fetch(0);
    step(DECODE, rnd(), "decode");
    step(ADDR, rnd(), "addr");
    step(MEM_WR, 1'b0, "mem_wr_wait");
    do_reset();

    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 4))
        0: run_alu(7'b0110011, $urandom_range(0, 4));
        1: run_alu(7'b0010011, $urandom_range(0, 4));
        2: run_load($urandom_range(0, 4), $urandom_range(0, 4));
        3: run_store($urandom_range(0, 4), $urandom_range(0, 4));
        default: run_branch($urandom_range(0, 4), rnd());
      endcase
    end
    check("bus_error_final", 32'(bus_error), 0);
    check("illegal_final", 32'(illegal), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Moore-style control sequencer for the multicycle RV32I datapath. It replaces the single-cycle Control block. It drives one shared memory port for both instruction and data access, and strobes the PC, IR, register-file and ALU-select controls across FETCH/DECODE/EXEC/MEM/WB steps. It also keeps a retired-instruction counter and a memory-handshake watchdog that traps on an unresponsive memory.

Parameters:
TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before trapping (≥1)
CNT_W, 32, width of retired-instruction counter

Ports:
CLK  in  1  rising-edge clock
RST  in  1  asynchronous reset, active-high
opcode  in  7  IR[6:0] of latched instruction
zero  in  1  ALU Zero flag
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory access request
mem_rw  out  1  0 read, 1 write
iord  out  1  0 address=PC, 1 address=ALUOut
ir_write  out  1  load IR from memory read data
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero=1
pc_src  out  2  00 ALU result, 01 ALUOut
alu_src_a  out  2  00 PC, 01 RS1, 10 old PC
alu_src_b  out  2  00 RS2, 01 const 4, 10 imm, 11 imm<<1
alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
reg_write  out  1  register-file write enable
mem_to_reg  out  1  0 ALUOut, 1 MDR
illegal  out  1  sticky: undecodable opcode
bus_error  out  1  sticky: watchdog expired
retired  out  CNT_W  completed-instruction count

Behaviour:
- RST high (async): state=IDLE, retired=0, watchdog=0, illegal=bus_error=0. All strobes (mem_req, ir_write, pc_write, pc_write_cond, reg_write) are 0. Selects are 00.
- Outputs decode combinationally from state, plus mem_ready where noted. Counters and the state register are updated only on CLK rising edge.
- IDLE: no outputs. Next state is FETCH unconditionally, so first fetch request appears 1 cycle after reset release.
- FETCH: mem_req=1, mem_rw=0, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write assert only in the cycle mem_ready=1.
  - mem_ready=1 → DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=10, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → ADDR
  - 1100011 → BRANCH
  - other → TRAP with illegal set
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10 → WB_ALU.
- EXEC_I: alu_src_a=01, alu_src_b=10, alu_op=10 → WB_ALU.
- ADDR: alu_src_a=01, alu_src_b=10, alu_op=00 → MEM_RD for load, MEM_WR for store.
- MEM_RD: mem_req=1, mem_rw=0, iord=1. Held until mem_ready, then → WB_MEM.
- MEM_WR: mem_req=1, mem_rw=1, iord=1. Held until mem_ready, then → FETCH and retire.
- WB_ALU: reg_write=1, mem_to_reg=0 → FETCH and retire.
- WB_MEM: reg_write=1, mem_to_reg=1 → FETCH and retire.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01 → FETCH and retire (taken or not).
- TRAP: all strobes 0, absorbing. Only RST exits it. retired is frozen.
- Retire: retired increments by 1 on the transition out of a completing state. It wraps modulo 2^CNT_W.
- Watchdog: counts cycles spent in FETCH/MEM_RD/MEM_WR with mem_ready=0, and clears on mem_ready or state change.
  - Reaching TIMEOUT → TRAP with bus_error set.
  - mem_ready arriving in the same cycle as the TIMEOUT-th wait wins: no trap.
- Cycle counts with zero wait states:
  - R/I-type: 4 cycles
  - load: 5
  - store: 4
  - branch: 3
- Reset asserted mid-instruction aborts immediately. No partial reg_write or memory write is issued after RST rises.

Decomposition:
- Shared package rv_ctrl_pkg:
  - state enum: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH
  - select encodings: ALUSRCA_*, ALUSRCB_*, ALUOP_*, PCSRC_*
- One sub-module, mem_watchdog: counter, clear, and expire flag, parameterised by TIMEOUT.

Test Plan:
- Reset release, opcode=0110011, mem_ready tied 1 → states IDLE, FETCH, DECODE, EXEC_R, WB_ALU. reg_write=1 in cycle 5. retired=1 after cycle 5.
- Load (0000011), memory responds 2 cycles late in MEM_RD → mem_req/iord=1 held 3 cycles. WB_MEM asserts reg_write with mem_to_reg=1. retired increments once.
- Store (0100011), mem_ready=1 → MEM_WR with mem_rw=1, then FETCH. reg_write is never asserted.
- Branch (1100011), zero=1, then repeat with zero=0 → pc_write_cond=1 with pc_src=01 in both runs. 3 cycles each. retired increases by 2.
- opcode=1111111 → TRAP with illegal=1. It stays there 20 cycles with all strobes 0. RST pulse returns to IDLE and clears illegal.
- TIMEOUT=16, mem_ready held 0 in FETCH → bus_error=1 after 16 wait cycles. A second run with mem_ready=1 on wait cycle 16 → no trap, DECODE entered.
